// File: rtl/alu_issue_ctrl.sv
// Purpose: sequences operand requests into the combinational ALU and hands results downstream.
// Latency: result valid one edge after the accept edge, plus MUL_LAT extra edges for multiply.
// Backpressure: holds the result until out_ready; in_ready low while executing, follows out_ready in HOLD.
module alu_issue_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_sel,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_sel,
    input  logic [31:0]      alu_r,
    input  logic             alu_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_r,
    output logic             out_z,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MWAIT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [2:0] OP_MUL  = 3'b100;

    logic [1:0] state;
    logic [3:0] wcnt;
    logic       accept;

    // HOLD passes downstream readiness straight through so back-to-back ops need no bubble.
    assign in_ready = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            alu_sel   <= 3'd0;
            out_valid <= 1'b0;
            out_r     <= 32'd0;
            out_z     <= 1'b0;
            out_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                S_MWAIT: begin
                    wcnt <= wcnt - 4'd1;
                    if (wcnt == 4'd1) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    out_r     <= alu_r;
                    out_z     <= alu_z;
                    out_err   <= (alu_sel == 3'b000) || (alu_sel == 3'b111);
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        op_count  <= op_count + CNT_W'(1);
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // An accept (from IDLE or a HOLD handoff) overrides the state chosen above.
            if (accept) begin
                alu_a   <= in_a;
                alu_b   <= in_b;
                alu_sel <= in_sel;
                if ((in_sel == OP_MUL) && (MUL_LAT > 0)) begin
                    wcnt  <= 4'(MUL_LAT);
                    state <= S_MWAIT;
                end else begin
                    state <= S_EXEC;
                end
            end
        end
    end

endmodule
